// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer: read-side consumer for a 4-bit asynchronous FIFO.
// It pops one nibble at a time, packs NIBBLES nibbles into a word and
// hands finished words downstream over a valid/ready handshake.
// A flush request emits a partially filled word, zero-padded.
// Optional feature macro: NIBPACK_PARITY_EN (registered even parity on word_parity).
module fifo_nibble_packer #(
  parameter int NIBBLES = 2,
  parameter int RD_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_re,
  input  logic [3:0]             fifo_rdata,
  input  logic                   flush,
  output logic [4*NIBBLES-1:0]   word_data,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   word_partial,
  output logic                   word_parity,
  output logic [2:0]             fill
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    OUT  = 3'd4
  } state_t;

  localparam logic [2:0] NIB_CNT   = 3'(NIBBLES);
  localparam logic [1:0] WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t               state_q;
  logic [1:0]           wait_q;
  logic [2:0]           fill_q;
  logic [2:0]           fill_inc;
  logic [4*NIBBLES-1:0] word_q;
  logic [4*NIBBLES-1:0] word_d;
  logic                 re_q;
  logic                 valid_q;
  logic                 partial_q;
  logic                 flush_take;
  logic                 capt_last;

  assign fill_inc   = fill_q + 3'd1;
  assign flush_take = (state_q == IDLE) && flush && (fill_q != 3'd0) && (fill_q < NIB_CNT);
  assign capt_last  = (state_q == CAPT) && (fill_inc == NIB_CNT);

  // The word as it will look once the returning nibble lands in slot fill.
  always_comb begin
    word_d = word_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (fill_q == 3'(i)) begin
        word_d[i*4 +: 4] = fifo_rdata;
      end
    end
  end

  // Main controller: one read in flight at a time, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= 2'd0;
      fill_q    <= 3'd0;
      word_q    <= '0;
      re_q      <= 1'b0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      re_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_take) begin
            state_q   <= OUT;
            valid_q   <= 1'b1;
            partial_q <= 1'b1;
          end else if (!fifo_empty) begin
            state_q <= POP;
            re_q    <= 1'b1;
          end
        end
        POP: begin
          if (RD_LAT > 1) begin
            state_q <= WAIT;
            wait_q  <= WAIT_LOAD;
          end else begin
            state_q <= CAPT;
          end
        end
        WAIT: begin
          if (wait_q == 2'd0) begin
            state_q <= CAPT;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        CAPT: begin
          word_q <= word_d;
          fill_q <= fill_inc;
          if (fill_inc == NIB_CNT) begin
            state_q   <= OUT;
            valid_q   <= 1'b1;
            partial_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        OUT: begin
          if (word_ready) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
            fill_q    <= 3'd0;
            word_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NIBPACK_PARITY_EN
  logic parity_q;

  // Parity is loaded in the same edge that raises word_valid and cleared on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (capt_last) begin
      parity_q <= ^word_d;
    end else if (flush_take) begin
      parity_q <= ^word_q;
    end else if ((state_q == OUT) && word_ready) begin
      parity_q <= 1'b0;
    end
  end

  assign word_parity = parity_q;
`else
  assign word_parity = 1'b0;
`endif

  assign fifo_re      = re_q;
  assign word_data    = word_q;
  assign word_valid   = valid_q;
  assign word_partial = partial_q;
  assign fill         = fill_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// tb_fifo_nibble_packer: two packer instances (2 nibbles / latency 1 and
// 4 nibbles / latency 3) fed by small FIFO models. Expected words are queued
// by the stimulus and compared by a negedge monitor at each handshake.
module tb_fifo_nibble_packer;

  typedef struct packed {
    logic [15:0] data;
    logic        partial;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic       emptyA, reA, flushA, validA, readyA, partialA, parityA;
  logic [3:0] rdataA;
  logic [7:0] dataA;
  logic [2:0] fillA;

  logic        emptyB, reB, flushB, validB, readyB, partialB, parityB;
  logic [3:0]  rdataB;
  logic [15:0] dataB;
  logic [2:0]  fillB;

  fifo_nibble_packer #(.NIBBLES(2), .RD_LAT(1)) dutA (
    .clk(clk), .rst(rst), .fifo_empty(emptyA), .fifo_re(reA), .fifo_rdata(rdataA),
    .flush(flushA), .word_data(dataA), .word_valid(validA), .word_ready(readyA),
    .word_partial(partialA), .word_parity(parityA), .fill(fillA)
  );

  fifo_nibble_packer #(.NIBBLES(4), .RD_LAT(3)) dutB (
    .clk(clk), .rst(rst), .fifo_empty(emptyB), .fifo_re(reB), .fifo_rdata(rdataB),
    .flush(flushB), .word_data(dataB), .word_valid(validB), .word_ready(readyB),
    .word_partial(partialB), .word_parity(parityB), .fill(fillB)
  );

  int checks = 0;
  int errors = 0;

  exp_t expA[$];
  exp_t expB[$];

  logic [3:0] memA [0:63];
  logic [3:0] memB [0:63];
  int wrA = 0, rdA = 0, cntA = 0;
  int wrB = 0, rdB = 0, cntB = 0;
  logic [3:0] pendA = 4'h0;
  logic [3:0] pendB = 4'h0;

  assign emptyA = (wrA == rdA);
  assign emptyB = (wrB == rdB);
  assign rdataA = (cntA == 1) ? pendA : ~pendA;
  assign rdataB = (cntB == 1) ? pendB : ~pendB;

  // FIFO A model: data is valid only in the one cycle before the capture edge.
  always @(posedge clk) begin
    if (reA) begin
      pendA <= memA[rdA % 64];
      rdA   <= rdA + 1;
      cntA  <= 1;
    end else if (cntA > 0) begin
      cntA <= cntA - 1;
    end
  end

  // FIFO B model: three-cycle read latency, same valid-window behaviour.
  always @(posedge clk) begin
    if (reB) begin
      pendB <= memB[rdB % 64];
      rdB   <= rdB + 1;
      cntB  <= 3;
    end else if (cntB > 0) begin
      cntB <= cntB - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic expParity(input logic [15:0] d);
`ifdef NIBPACK_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: checks read legality and scores every word transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (reA) checkOutput("A fifo_re while empty", 32'(emptyA), 32'd0);
      if (reB) checkOutput("B fifo_re while empty", 32'(emptyB), 32'd0);
      if (validA && readyA) begin
        if (expA.size() == 0) begin
          checkOutput("A unexpected word", 32'(dataA), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = expA.pop_front();
          checkOutput("A word_data", 32'(dataA), 32'(e.data[7:0]));
          checkOutput("A word_partial", 32'(partialA), 32'(e.partial));
          checkOutput("A word_parity", 32'(parityA), 32'(expParity({8'h00, e.data[7:0]})));
        end
      end
      if (validB && readyB) begin
        if (expB.size() == 0) begin
          checkOutput("B unexpected word", 32'(dataB), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = expB.pop_front();
          checkOutput("B word_data", 32'(dataB), 32'(e.data));
          checkOutput("B word_partial", 32'(partialB), 32'(e.partial));
          checkOutput("B word_parity", 32'(parityB), 32'(expParity(e.data)));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusA(input logic [3:0] n);
    memA[wrA % 64] = n;
    wrA++;
  endtask

  task automatic applyStimulusB(input logic [3:0] n);
    memB[wrB % 64] = n;
    wrB++;
  endtask

  task automatic waitDrainA(input string name);
    for (int i = 0; i < 100 && expA.size() != 0; i++) tick();
    checkOutput(name, 32'(expA.size()), 32'd0);
  endtask

  task automatic waitDrainB(input string name);
    for (int i = 0; i < 100 && expB.size() != 0; i++) tick();
    checkOutput(name, 32'(expB.size()), 32'd0);
  endtask

  task automatic waitFillB(input logic [2:0] v, input string name);
    for (int i = 0; i < 60 && fillB != v; i++) tick();
    checkOutput(name, 32'(fillB), 32'(v));
  endtask

  int rePulses, badCycles, firstRe, secondRe;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flushA = 1'b0; flushB = 1'b0; readyA = 1'b0; readyB = 1'b0;
    #1;
    checkOutput("A reset outputs", {reA, validA, partialA, parityA, fillA, dataA}, 32'd0);
    checkOutput("B reset outputs", {reB, validB, partialB, parityB, fillB, dataB}, 32'd0);
    tick(2);
    rst = 1'b0;

    // Full word A then 5 on the 2-nibble instance
    readyA = 1'b1;
    expA.push_back('{data: 16'h005A, partial: 1'b0});
    applyStimulusA(4'hA);
    applyStimulusA(4'h5);
    for (int i = 0; i < 20 && fillA != 3'd1; i++) tick();
    checkOutput("A fill after first nibble", 32'(fillA), 32'd1);
    checkOutput("A low nibble after first capture", 32'(dataA[3:0]), 32'hA);
    waitDrainA("A full word drained");
    tick();
    checkOutput("A valid after accept", 32'(validA), 32'd0);

    // Backpressure: word held while a further nibble waits in the FIFO
    readyA = 1'b0;
    expA.push_back('{data: 16'h00C3, partial: 1'b0});
    applyStimulusA(4'h3);
    applyStimulusA(4'hC);
    applyStimulusA(4'h7);
    for (int i = 0; i < 30 && !validA; i++) tick();
    checkOutput("A valid under backpressure", 32'(validA), 32'd1);
    rePulses = 0; badCycles = 0;
    repeat (10) begin
      tick();
      if (reA) rePulses++;
      if (!validA || dataA != 8'hC3) badCycles++;
    end
    checkOutput("A fifo_re during backpressure", 32'(rePulses), 32'd0);
    checkOutput("A word unstable during backpressure", 32'(badCycles), 32'd0);
    readyA = 1'b1;
    tick();
    checkOutput("A valid after release", 32'(validA), 32'd0);
    checkOutput("A fill after release", 32'(fillA), 32'd0);
    expA.push_back('{data: 16'h0087, partial: 1'b0});
    applyStimulusA(4'h8);
    waitDrainA("A second word drained");
    tick();

    // Reset in the middle of a latency-3 read
    readyB = 1'b1;
    applyStimulusB(4'hE);
    for (int i = 0; i < 20 && !reB; i++) tick();
    checkOutput("B pop seen", 32'(reB), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("B outputs on mid-read reset", {reB, validB, partialB, parityB, fillB, dataB}, 32'd0);
    applyStimulusB(4'h3);
    tick();
    rst = 1'b0;
    checkOutput("B no re at release", 32'(reB), 32'd0);
    tick();
    checkOutput("B first re after reset", 32'(reB), 32'd1);

    // Flush of a single captured nibble
    expB.push_back('{data: 16'h0003, partial: 1'b1});
    waitFillB(3'd1, "B fill before flush");
    flushB = 1'b1;
    tick();
    flushB = 1'b0;
    checkOutput("B flushed valid", 32'(validB), 32'd1);
    checkOutput("B flushed data", 32'(dataB), 32'h0003);
    waitDrainB("B flushed word drained");
    tick();

    // Flush with nothing captured produces nothing
    flushB = 1'b1;
    badCycles = 0;
    repeat (6) begin
      tick();
      if (validB) badCycles++;
    end
    flushB = 1'b0;
    checkOutput("B valid on empty flush", 32'(badCycles), 32'd0);

    // Empty stall, then pulse spacing of RD_LAT+2
    rePulses = 0;
    repeat (20) begin
      tick();
      if (reB) rePulses++;
    end
    checkOutput("B re while FIFO empty", 32'(rePulses), 32'd0);
    applyStimulusB(4'h1);
    applyStimulusB(4'h2);
    rePulses = 0; firstRe = -1; secondRe = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (reB) begin
        rePulses++;
        if (firstRe < 0) firstRe = c;
        else if (secondRe < 0) secondRe = c;
      end
    end
    checkOutput("B pulse count", 32'(rePulses), 32'd2);
    checkOutput("B pulse spacing", 32'(secondRe - firstRe), 32'd5);
    checkOutput("B fill after two nibbles", 32'(fillB), 32'd2);
    expB.push_back('{data: 16'h4321, partial: 1'b0});
    applyStimulusB(4'h3);
    applyStimulusB(4'h4);
    waitDrainB("B full word drained");
    tick();

    // Flush and non-empty FIFO together: flush wins
    expB.push_back('{data: 16'h0009, partial: 1'b1});
    applyStimulusB(4'h9);
    waitFillB(3'd1, "B fill before tie");
    applyStimulusB(4'h6);
    flushB = 1'b1;
    tick();
    flushB = 1'b0;
    checkOutput("B re on flush tie", 32'(reB), 32'd0);
    checkOutput("B partial on flush tie", 32'(partialB), 32'd1);
    waitDrainB("B tie word drained");
    tick();
    expB.push_back('{data: 16'h0006, partial: 1'b1});
    waitFillB(3'd1, "B fill after tie");
    flushB = 1'b1;
    tick();
    flushB = 1'b0;
    waitDrainB("B last word drained");
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_nibble_packer.md
# fifo_nibble_packer

Read-side consumer that sits directly downstream of the 8-deep, 4-bit asynchronous FIFO in its read clock domain. It watches the FIFO empty flag, issues single-cycle read-enable pulses, captures the returned nibbles and packs them into wider words. Completed words go to the next stage over a valid/ready handshake. A flush input lets a partially filled word be emitted zero-padded.

## Interface
Parameters:
- NIBBLES, 2: nibbles per output word; legal 2..4.
- RD_LAT, 1: cycles from the fifo_re pulse to valid fifo_rdata; legal 1..3.

Ports:
- clk  in  1  single clock (the FIFO read clock).
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_re  out  1  FIFO read enable, single-cycle pulse.
- fifo_rdata  in  4  FIFO read data.
- flush  in  1  emit the partial word (level, sampled in IDLE only).
- word_data  out  4*NIBBLES  packed word; first nibble popped lands in [3:0].
- word_valid  out  1  word available.
- word_ready  in  1  downstream accepts.
- word_partial  out  1  current word was produced by flush.
- word_parity  out  1  even parity of word_data (see Configuration).
- fill  out  3  nibbles captured into the word being assembled.

## Operation
- FSM states: IDLE, POP, WAIT, CAPT, OUT. Reset state is IDLE.
- IDLE:
  - If flush=1 and 0<fill<NIBBLES, go to OUT with word_partial=1. Flush has priority over a pending pop.
  - Otherwise, if fifo_empty=0, go to POP.
  - flush with fill=0 is ignored.
- POP: fifo_re=1 for exactly this cycle, then go to WAIT if RD_LAT>1, else CAPT.
- WAIT: a down-counter runs RD_LAT-1 cycles, then goes to CAPT.
- CAPT: shift fifo_rdata into nibble slot fill and do fill+1.
  - If the new fill equals NIBBLES, go to OUT with word_partial=0.
  - Otherwise go to IDLE.
- OUT:
  - word_valid=1; word_data, word_partial and word_parity are held stable.
  - When word_ready=1 at a rising edge, the transfer completes. Next state is IDLE, fill=0, the shift register clears to 0 and word_partial clears.
- Only one read is outstanding at a time. fifo_re is never asserted outside POP and never while fifo_empty was sampled 1.
- Unfilled slots of a flushed word are 4'h0.
- fill is a 3-bit register; it never exceeds NIBBLES.
- word_ready is ignored outside OUT.
- flush is ignored outside IDLE and is not latched.

## Timing
- Reset: all outputs (fifo_re, word_valid, word_data, word_partial, word_parity, fill) are 0 immediately on rst assertion; the state is IDLE.
- Reset mid-read: the in-flight nibble is discarded (the FIFO has already advanced; the loss is accepted).
- Pop latency: with IDLE and fifo_empty=0 at edge t, fifo_re is high during cycle t+1.
- Capture: data is sampled at edge t+1+RD_LAT, with fill incrementing at that edge.
- Per-nibble cost: RD_LAT+2 cycles (IDLE, POP, RD_LAT cycles of WAIT/CAPT).
- Full-word latency: word_valid rises on the edge after the final CAPT, and can stay high indefinitely under backpressure.
- Back-to-back words: the first POP of the next word occurs at the earliest two cycles after the accept edge (OUT→IDLE→POP).
- Flush: word_valid rises one edge after IDLE samples flush=1.

## Configuration
- NIBPACK_PARITY_EN defined: word_parity is a registered XOR of all word_data bits. It is updated together with word_data and valid whenever word_valid=1.
- NIBPACK_PARITY_EN undefined: word_parity is tied to 0 and no parity logic is synthesised.

## Test plan
- Reset: assert rst mid-WAIT → all outputs 0 at once, fill=0. After release with fifo_empty=0, the first fifo_re appears two edges later.
- Full word, NIBBLES=2, RD_LAT=1: FIFO returns 4'hA then 4'h5 → word_data=8'h5A, word_valid=1, word_partial=0. word_parity=0 with NIBPACK_PARITY_EN (0 without).
- Backpressure: word_ready held 0 for 10 cycles → word_data stable and no fifo_re pulses. word_ready=1 → valid drops next cycle, fill=0.
- Flush: NIBBLES=4, one nibble 4'h3 captured, then flush=1 → word_data=16'h0003, word_partial=1. Flush with fill=0 → no word.
- Empty stall: fifo_empty=1 throughout → fifo_re is never asserted. Deassert fifo_empty → exactly one pulse per nibble, spaced RD_LAT+2 cycles (RD_LAT=3 gives 5).
- Simultaneous flush and fifo_empty=0 in IDLE with fill=1 → flush wins, no fifo_re that cycle, partial word emitted.
